// File: rtl/inference_pkg.sv
// inference_pkg: constants and types shared by the inference sequencer and its valid pipe.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inference_pkg;

    localparam int ROWS     = 8;   // weight words per load, array dimension
    localparam int PIPE_LAT = 17;  // ROWS + 7 deskew + bias + activation, in enabled cycles
    localparam int VEC_W    = 64;

    typedef logic [VEC_W-1:0] vec_t;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_WAIT_W = 3'd1;
    localparam state_t ST_LOAD_W = 3'd2;
    localparam state_t ST_STREAM = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

endpackage

// File: rtl/valid_pipe.sv
// valid_pipe: enabled bit shift register whose tail marks a real result on the datapath output.
// Latency: a bit shifted in appears on tail after DEPTH shifts.
// Backpressure: holds its contents whenever shift is low; clr empties it.
// Ports: clk, n_rst (async active-low), clr (sync clear), shift, din, tail.
module valid_pipe #(
    parameter int DEPTH = 17
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic shift,
    input  logic din,
    output logic tail
);

    logic [DEPTH-1:0] bits;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bits <= '0;
        end else if (clr) begin
            bits <= '0;
        end else if (shift) begin
            bits <= {bits[DEPTH-2:0], din};
        end
    end

    assign tail = bits[DEPTH-1];

endmodule

// File: rtl/inference_sequencer.sv
// inference_sequencer: runs one datapath layer pass - weight load, input streaming, drain, result hand-off.
// Latency: first result PIPE_LAT enabled cycles after its input word is fed; load is ROWS cycles after weights are ready.
// Backpressure: out_ready low or an empty input buffer drops enable and freezes the datapath; weight load never stalls.
// Ports: cmd_* command/status; weight_*/input_* buffer read side; start_weights/start_array/enable/systolic_data and
//        activations to/from the datapath; out_data/out_valid/out_ready result port.
module inference_sequencer #(
    parameter int ROWS     = inference_pkg::ROWS,
    parameter int PIPE_LAT = inference_pkg::PIPE_LAT,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             cmd_start,
    input  logic [CNT_W-1:0] cmd_num_inputs,
    output logic             cmd_busy,
    output logic             cmd_done,
    output logic             cmd_error,
    input  logic [3:0]       weight_level,
    input  logic [63:0]      weight_data,
    output logic             weight_rd_en,
    input  logic             input_empty,
    input  logic [63:0]      input_data,
    output logic             input_rd_en,
    output logic             start_weights,
    output logic             start_array,
    output logic             enable,
    output logic [63:0]      systolic_data,
    input  logic [63:0]      activations,
    output logic [63:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    import inference_pkg::*;

    localparam int         LD_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(ROWS - 1);
    localparam logic [3:0] ROWS_LVL = 4'(ROWS);

    state_t           state;
    logic [CNT_W-1:0] n_req;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [LD_W-1:0]  ld_cnt;
    logic             first_stream;
    logic             taken;
    logic             err_q;

    logic in_stream;
    logic in_load;
    logic accept;
    logic all_fed;
    logic feed;
    logic stall;
    logic stream_en;
    logic tail;
    logic hs;

    assign in_stream = (state == ST_STREAM);
    assign in_load   = (state == ST_LOAD_W);
    assign accept    = (state == ST_IDLE) && cmd_start && (cmd_num_inputs != '0);

    // Once every input is in, zeros are pushed with enable high to drain the pipe.
    assign all_fed   = (in_cnt == n_req);
    assign feed      = in_stream && (in_cnt < n_req) && !input_empty;
    assign stall     = out_valid && !out_ready;
    assign stream_en = in_stream && !stall && (feed || all_fed);

    // A result handed off while the pipe is frozen stays on activations; taken hides it until the next shift.
    assign out_valid = tail && !taken;
    assign hs        = out_valid && out_ready;

    valid_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_valid_pipe (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (accept),
        .shift (stream_en),
        .din   (feed),
        .tail  (tail)
    );

    assign enable        = in_load || stream_en;
    assign weight_rd_en  = in_load;
    assign start_weights = in_load && (ld_cnt == '0);
    assign start_array   = in_stream && first_stream;
    assign input_rd_en   = stream_en && feed;
    assign systolic_data = in_load ? weight_data : (input_rd_en ? input_data : '0);
    assign out_data      = out_valid ? activations : '0;
    assign cmd_busy      = (state == ST_WAIT_W) || in_load || in_stream;
    assign cmd_done      = (state == ST_DONE);
    assign cmd_error     = err_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            n_req        <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            ld_cnt       <= '0;
            first_stream <= 1'b0;
            taken        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= (state == ST_IDLE) && cmd_start && (cmd_num_inputs == '0);
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        n_req   <= cmd_num_inputs;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        taken   <= 1'b0;
                        state   <= ST_WAIT_W;
                    end
                end
                // The datapath weight load cannot pause, so all ROWS words must be present first.
                ST_WAIT_W: begin
                    if (weight_level >= ROWS_LVL) begin
                        ld_cnt <= '0;
                        state  <= ST_LOAD_W;
                    end
                end
                ST_LOAD_W: begin
                    ld_cnt <= ld_cnt + 1'b1;
                    if (ld_cnt == LD_LAST) begin
                        first_stream <= 1'b1;
                        state        <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    first_stream <= 1'b0;
                    if (input_rd_en) begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                    if (hs) begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                    if (stream_en) begin
                        taken <= 1'b0;
                    end else if (hs) begin
                        taken <= 1'b1;
                    end
                    if (all_fed && (out_cnt == n_req)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: scoreboard bench for inference_sequencer with buffer and datapath stand-ins.
// Latency: the datapath stand-in delays systolic_data by PIPE_LAT enabled cycles and scrambles it.
// Backpressure: out_ready and input_empty are driven per scenario.
module tb_inference_sequencer;

    localparam int PIPE_LAT = 17;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic [6:0]  cmd_num_inputs = '0;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_error;
    logic [3:0]  weight_level = '0;
    logic [63:0] weight_data;
    logic        weight_rd_en;
    logic        input_empty;
    logic [63:0] input_data;
    logic        input_rd_en;
    logic        start_weights;
    logic        start_array;
    logic        enable;
    logic [63:0] systolic_data;
    logic [63:0] activations;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;

    always #5 clk = ~clk;

    inference_sequencer dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .cmd_start      (cmd_start),
        .cmd_num_inputs (cmd_num_inputs),
        .cmd_busy       (cmd_busy),
        .cmd_done       (cmd_done),
        .cmd_error      (cmd_error),
        .weight_level   (weight_level),
        .weight_data    (weight_data),
        .weight_rd_en   (weight_rd_en),
        .input_empty    (input_empty),
        .input_data     (input_data),
        .input_rd_en    (input_rd_en),
        .start_weights  (start_weights),
        .start_array    (start_array),
        .enable         (enable),
        .systolic_data  (systolic_data),
        .activations    (activations),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
    );

    // Datapath stand-in transform; expected results come from this applied to each popped input word.
    function automatic logic [63:0] dp_fn(input logic [63:0] x);
        return {x[31:0], x[63:32]} ^ 64'h5A5A_0F0F_C3C3_9696;
    endfunction

    // Weight buffer: head word tagged with a pop counter.
    logic [7:0] wpop = '0;
    assign weight_data = {32'hBEEF_0000, 24'h0, wpop};
    always @(posedge clk) if (weight_rd_en) wpop <= wpop + 8'd1;

    // Input buffer with optional every-other-cycle bubbles.
    logic [63:0] in_mem [0:255];
    int   in_wr = 0;
    int   in_rd = 0;
    logic flush = 1'b0;
    logic bubble_mode = 1'b0;
    logic bubble = 1'b0;
    assign input_empty = (in_rd == in_wr) || bubble;
    assign input_data  = in_mem[in_rd[7:0]];
    always @(posedge clk) begin
        if (flush) in_rd <= in_wr;
        else if (input_rd_en) in_rd <= in_rd + 1;
        if (bubble_mode) bubble <= ~bubble;
        else bubble <= 1'b0;
    end

    // Datapath stand-in: PIPE_LAT-deep enabled delay line.
    logic [63:0] dp [PIPE_LAT];
    always @(posedge clk) begin
        if (enable) begin
            dp[0] <= systolic_data;
            for (int i = 1; i < PIPE_LAT; i++) dp[i] <= dp[i-1];
        end
    end
    assign activations = dp_fn(dp[PIPE_LAT-1]);

    // Bench bookkeeping, all owned by the single initial process.
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int sw_tot = 0, wrd_tot = 0, sa_tot = 0, en_tot = 0, pop_tot = 0;
    int hs_tot = 0, ov_tot = 0, done_tot = 0, err_tot = 0;
    int last_wrd = 0, wrd_rise = 0, sa_cycle = 0;
    int pop_base = 0, cur_n = 0, lat_cnt = 0;
    logic prev_wrd = 1'b0, in_stream = 1'b0, lat_armed = 1'b0, lat_done = 1'b0;
    logic s_valid = 1'b0, s_busy = 1'b0;
    logic [63:0] s_data = '0;
    logic [63:0] exp_q [$];

    // One clock: sample and check at the falling edge, return just after the rising edge for driving.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        cycle++;
        s_valid = out_valid;
        s_data  = out_data;
        s_busy  = cmd_busy;
        if (start_weights) sw_tot++;
        if (enable) en_tot++;
        if (cmd_done) done_tot++;
        if (cmd_error) err_tot++;
        if (weight_rd_en) begin
            wrd_tot++;
            last_wrd = cycle;
            if (!prev_wrd) wrd_rise = cycle;
            checks++;
            if (systolic_data !== weight_data) begin
                errors++;
                $display("FAIL weight_word: got %h want %h", systolic_data, weight_data);
            end
        end
        prev_wrd = weight_rd_en;
        if (start_array) begin
            sa_tot++;
            sa_cycle = cycle;
            in_stream = 1'b1;
        end
        if (in_stream && input_empty && (pop_tot - pop_base) < cur_n) begin
            checks++;
            if (enable !== 1'b0) begin
                errors++;
                $display("FAIL enable_on_empty: enable=%b want 0", enable);
            end
        end
        if (out_valid && !out_ready) begin
            checks++;
            if (enable !== 1'b0 || input_rd_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: enable=%b rd_en=%b want 0 0", enable, input_rd_en);
            end
        end
        if (input_rd_en) begin
            pop_tot++;
            checks++;
            if (systolic_data !== input_data || enable !== 1'b1) begin
                errors++;
                $display("FAIL feed_word: got %h en=%b want %h en=1", systolic_data, enable, input_data);
            end
            exp_q.push_back(dp_fn(input_data));
            if (!lat_armed && !lat_done) begin
                lat_armed = 1'b1;
                lat_cnt = 0;
            end
        end
        if (out_valid) begin
            ov_tot++;
            if (lat_armed) begin
                checks++;
                if (lat_cnt != PIPE_LAT) begin
                    errors++;
                    $display("FAIL first_result_latency: got %0d want %0d", lat_cnt, PIPE_LAT);
                end
                lat_armed = 1'b0;
                lat_done = 1'b1;
            end
            if (out_ready) begin
                hs_tot++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result_extra: got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        errors++;
                        $display("FAIL result_data: got %h want %h", out_data, e);
                    end
                end
            end
        end
        if (lat_armed && enable) lat_cnt++;
        if (cmd_done) begin
            in_stream = 1'b0;
            lat_armed = 1'b0;
            lat_done = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_inputs(input int k);
        for (int i = 0; i < k; i++) begin
            in_mem[in_wr[7:0]] = {$urandom, $urandom};
            in_wr++;
        end
    endtask

    task automatic issue_cmd(input int n);
        cur_n = n;
        pop_base = pop_tot;
        cmd_num_inputs = 7'(n);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        int n;
        d0 = done_tot;
        n = 0;
        while (done_tot == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_tot == d0) begin
            errors++;
            $display("FAIL %s_timeout: no cmd_done after %0d cycles", name, budget);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({cmd_busy, cmd_done, cmd_error, weight_rd_en, input_rd_en, start_weights,
             start_array, enable, out_valid} !== 9'b0) begin
            errors++;
            $display("FAIL %s_ctrl: got %b want 0", name, {cmd_busy, cmd_done, cmd_error, weight_rd_en,
                     input_rd_en, start_weights, start_array, enable, out_valid});
        end
        checks++;
        if (systolic_data !== 64'h0 || out_data !== 64'h0) begin
            errors++;
            $display("FAIL %s_data: systolic %h out %h want 0 0", name, systolic_data, out_data);
        end
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 n_rst = 1'b1;
        tick();
        check_eq("reset_busy", int'(s_busy), 0);
    endtask

    task automatic test_basic();
        int b_sw, b_wrd, b_sa, b_pop, b_hs, b_ov, b_done;
        b_sw = sw_tot; b_wrd = wrd_tot; b_sa = sa_tot; b_pop = pop_tot;
        b_hs = hs_tot; b_ov = ov_tot; b_done = done_tot;
        weight_level = 4'd8;
        out_ready = 1'b1;
        push_inputs(4);
        issue_cmd(4);
        tick();
        check_eq("basic_busy", int'(s_busy), 1);
        wait_done(400, "basic");
        check_eq("basic_busy_at_done", int'(s_busy), 0);
        check_eq("basic_start_weights", sw_tot - b_sw, 1);
        check_eq("basic_weight_pops", wrd_tot - b_wrd, 8);
        check_eq("basic_start_array", sa_tot - b_sa, 1);
        check_eq("basic_start_array_cycle", sa_cycle, last_wrd + 1);
        check_eq("basic_input_pops", pop_tot - b_pop, 4);
        check_eq("basic_valid_cycles", ov_tot - b_ov, 4);
        check_eq("basic_results", hs_tot - b_hs, 4);
        check_eq("basic_done", done_tot - b_done, 1);
        check_eq("basic_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_weight_starve();
        int b_wrd, b_en, lvl_cycle;
        weight_level = 4'd5;
        push_inputs(2);
        issue_cmd(2);
        b_wrd = wrd_tot;
        b_en = en_tot;
        repeat (10) tick();
        check_eq("starve_weight_pops", wrd_tot - b_wrd, 0);
        check_eq("starve_enable", en_tot - b_en, 0);
        weight_level = 4'd8;
        lvl_cycle = cycle + 1;
        wait_done(400, "starve");
        // WAIT_W sees the level in lvl_cycle and the load occupies the following cycles.
        check_eq("starve_load_start", wrd_rise, lvl_cycle + 1);
        check_eq("starve_weight_total", wrd_tot - b_wrd, 8);
    endtask

    task automatic test_bubbles();
        int b_pop, b_hs;
        b_pop = pop_tot; b_hs = hs_tot;
        push_inputs(6);
        bubble_mode = 1'b1;
        issue_cmd(6);
        wait_done(500, "bubbles");
        bubble_mode = 1'b0;
        check_eq("bubbles_pops", pop_tot - b_pop, 6);
        check_eq("bubbles_results", hs_tot - b_hs, 6);
        check_eq("bubbles_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_backpressure();
        int b_pop, b_hs, n;
        logic [63:0] held;
        b_pop = pop_tot; b_hs = hs_tot;
        out_ready = 1'b1;
        push_inputs(6);
        issue_cmd(6);
        n = 0;
        while (!s_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("bp_first_valid", int'(s_valid), 1);
        out_ready = 1'b0;
        tick();
        held = s_data;
        check_eq("bp_valid_held", int'(s_valid), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_data !== held) begin
                errors++;
                $display("FAIL bp_data_stable: got %b %h want 1 %h", s_valid, s_data, held);
            end
        end
        out_ready = 1'b1;
        wait_done(400, "bp");
        check_eq("bp_pops", pop_tot - b_pop, 6);
        check_eq("bp_results", hs_tot - b_hs, 6);
        check_eq("bp_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_held_result();
        int b_hs0, b_hs, n;
        b_hs0 = hs_tot;
        out_ready = 1'b1;
        push_inputs(20);
        issue_cmd(21);
        n = 0;
        while ((pop_tot - pop_base) < 20 && n < 300) begin
            tick();
            n++;
        end
        check_eq("held_pops_before_gap", pop_tot - pop_base, 20);
        // Input runs dry with one result on the tail: it leaves once and must not reappear.
        b_hs = hs_tot;
        repeat (8) tick();
        check_eq("held_gap_results", hs_tot - b_hs, 1);
        push_inputs(1);
        wait_done(400, "held");
        check_eq("held_results", hs_tot - b_hs0, 21);
        check_eq("held_queue_left", exp_q.size(), 0);
    endtask

    task automatic test_zero_count();
        int b_err, b_pop, b_wrd;
        logic busy_seen;
        b_err = err_tot; b_pop = pop_tot; b_wrd = wrd_tot;
        cmd_num_inputs = 7'd0;
        cmd_start = 1'b1;
        tick();
        busy_seen = s_busy;
        cmd_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            busy_seen = busy_seen | s_busy;
        end
        check_eq("zero_error_pulses", err_tot - b_err, 1);
        check_eq("zero_busy", int'(busy_seen), 0);
        check_eq("zero_pops", (pop_tot - b_pop) + (wrd_tot - b_wrd), 0);
    endtask

    task automatic test_back_to_back();
        int b_hs, b_done;
        b_hs = hs_tot; b_done = done_tot;
        push_inputs(4);
        cur_n = 2;
        pop_base = pop_tot;
        cmd_num_inputs = 7'd2;
        cmd_start = 1'b1;
        tick();
        wait_done(400, "b2b_first");
        // cmd_start stayed high through DONE; only the next IDLE cycle may accept it.
        tick();
        check_eq("b2b_idle_gap_busy", int'(s_busy), 0);
        pop_base = pop_tot;
        cmd_start = 1'b0;
        tick();
        check_eq("b2b_second_busy", int'(s_busy), 1);
        wait_done(400, "b2b_second");
        check_eq("b2b_results", hs_tot - b_hs, 4);
        check_eq("b2b_done", done_tot - b_done, 2);
    endtask

    task automatic test_reset_stream();
        int b_done, b_hs, n;
        push_inputs(8);
        issue_cmd(8);
        n = 0;
        while ((pop_tot - pop_base) < 3 && n < 200) begin
            tick();
            n++;
        end
        check_eq("rst_pops_before", pop_tot - pop_base, 3);
        b_done = done_tot;
        n_rst = 1'b0;
        #1;
        check_outputs_zero("rst_stream");
        exp_q.delete();
        in_stream = 1'b0;
        lat_armed = 1'b0;
        lat_done = 1'b0;
        prev_wrd = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3) tick();
        check_eq("rst_no_done", done_tot - b_done, 0);
        b_hs = hs_tot;
        push_inputs(4);
        issue_cmd(4);
        wait_done(400, "rst_rerun");
        check_eq("rst_rerun_results", hs_tot - b_hs, 4);
        check_eq("rst_rerun_done", done_tot - b_done, 1);
        check_eq("rst_rerun_queue_left", exp_q.size(), 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_weight_starve();
        test_bubbles();
        test_backpressure();
        test_held_result();
        test_zero_count();
        test_back_to_back();
        test_reset_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
